// File: rtl/alarm_ctrl_pkg.sv
// Shared types and defaults for the alarm controller: state encodings,
// button selection and timer defaults.
package alarm_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSetH    = 3'd1,
        StSetM    = 3'd2,
        StArmed   = 3'd3,
        StRinging = 3'd4,
        StSnooze  = 3'd5
    } alarm_state_e;

    typedef enum logic [2:0] {
        BtnNone   = 3'd0,
        BtnStop   = 3'd1,
        BtnArm    = 3'd2,
        BtnSnooze = 3'd3,
        BtnSet    = 3'd4,
        BtnInc    = 3'd5
    } btn_e;

    localparam int unsigned DefRingTicks   = 8;
    localparam int unsigned DefSnoozeTicks = 5;
    localparam int unsigned DefMaxSnooze   = 3;

    // Only the highest-priority pulse in a cycle acts; the rest are dropped.
    function automatic btn_e pick_btn(input logic stop, input logic arm, input logic snooze,
                                      input logic set, input logic inc);
        if (stop)   return BtnStop;
        if (arm)    return BtnArm;
        if (snooze) return BtnSnooze;
        if (set)    return BtnSet;
        if (inc)    return BtnInc;
        return BtnNone;
    endfunction

endpackage

// File: rtl/alarm_tick_timer.sv
// Tick-enabled up-counter; done pulses on the tick that completes LIMIT ticks.
module alarm_tick_timer #(
    parameter int unsigned LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic done
);

    localparam int unsigned CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LastCnt  = CW'(LIMIT - 1);
    localparam logic [CW-1:0] LimitCnt = CW'(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != LimitCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = tick && !clear && (cnt_q == LastCnt);

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencing controller: setpoint entry, arm/disarm, match detection,
// ringing with timeout and bounded snooze.
module alarm_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int unsigned W            = 2,
    parameter int unsigned RING_TICKS   = DefRingTicks,
    parameter int unsigned SNOOZE_TICKS = DefSnoozeTicks,
    parameter int unsigned MAX_SNOOZE   = DefMaxSnooze
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic [W-1:0] hours,
    input  logic [W-1:0] minutes,
    input  logic [W-1:0] seconds,
    input  logic         set_btn,
    input  logic         inc_btn,
    input  logic         arm_btn,
    input  logic         snooze_btn,
    input  logic         stop_btn,
    output logic [W-1:0] alarm_hours,
    output logic [W-1:0] alarm_minutes,
    output logic [2:0]   state,
    output logic         armed,
    output logic         ring
);

    localparam int unsigned SUW = $clog2(MAX_SNOOZE + 1);
    localparam logic [SUW-1:0] MaxSnz = SUW'(MAX_SNOOZE);

    alarm_state_e   state_q, state_d;
    logic [W-1:0]   ah_q, ah_d, am_q, am_d;
    logic [SUW-1:0] snooze_used_q, snooze_used_d;
    logic           match, match_q, trigger;
    logic           ring_done, snz_done;
    btn_e           btn;

    assign btn     = pick_btn(stop_btn, arm_btn, snooze_btn, set_btn, inc_btn);
    assign match   = (hours == ah_q) && (minutes == am_q) && (seconds == '0);
    assign trigger = match && !match_q;

    // Timers are held clear outside their state, so every entry starts from zero.
    alarm_tick_timer #(.LIMIT(RING_TICKS)) u_ring_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q != StRinging),
        .tick  (tick),
        .done  (ring_done)
    );

    alarm_tick_timer #(.LIMIT(SNOOZE_TICKS)) u_snz_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q != StSnooze),
        .tick  (tick),
        .done  (snz_done)
    );

    always_comb begin
        state_d       = state_q;
        ah_d          = ah_q;
        am_d          = am_q;
        snooze_used_d = snooze_used_q;
        unique case (state_q)
            StIdle: begin
                if (btn == BtnArm)      state_d = StArmed;
                else if (btn == BtnSet) state_d = StSetH;
            end
            StSetH: begin
                if (btn == BtnInc)      ah_d = ah_q + 1'b1;
                else if (btn == BtnSet) state_d = StSetM;
                else if (btn == BtnArm) state_d = StIdle;
            end
            StSetM: begin
                if (btn == BtnInc)      am_d = am_q + 1'b1;
                else if (btn == BtnSet) state_d = StIdle;
                else if (btn == BtnArm) state_d = StArmed;
            end
            StArmed: begin
                if (btn == BtnArm)      state_d = StIdle;
                else if (btn == BtnSet) state_d = StSetH;
                else if (trigger)       state_d = StRinging;
            end
            StRinging: begin
                if (btn == BtnStop) begin
                    state_d = StArmed;
                end else if (btn == BtnArm) begin
                    state_d = StIdle;
                end else if ((btn == BtnSnooze) && (snooze_used_q < MaxSnz)) begin
                    state_d       = StSnooze;
                    snooze_used_d = snooze_used_q + 1'b1;
                end else if (ring_done) begin
                    state_d = StArmed;
                end
            end
            StSnooze: begin
                if (btn == BtnStop)     state_d = StArmed;
                else if (btn == BtnArm) state_d = StIdle;
                else if (snz_done)      state_d = StRinging;
            end
            default: state_d = StIdle;
        endcase
        if ((state_d == StIdle) || (state_d == StArmed)) begin
            snooze_used_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ah_q          <= '0;
            am_q          <= '0;
            snooze_used_q <= '0;
            match_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ah_q          <= ah_d;
            am_q          <= am_d;
            snooze_used_q <= snooze_used_d;
            match_q       <= match;
        end
    end

    assign alarm_hours   = ah_q;
    assign alarm_minutes = am_q;
    assign state         = state_q;
    assign ring          = (state_q == StRinging);
    assign armed         = (state_q == StArmed) || (state_q == StRinging) ||
                           (state_q == StSnooze);

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: vector table, directed corner sequences
// and randomized traffic against a behavioural model.
module tb_alarm_ctrl;
    import alarm_ctrl_pkg::*;

    localparam int RING = 8;
    localparam int SNZ  = 5;
    localparam int MAXS = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick, set_btn, inc_btn, arm_btn, snooze_btn, stop_btn;
    logic [1:0] hours, minutes, seconds;
    logic [1:0] alarm_hours, alarm_minutes;
    logic [2:0] state;
    logic       armed, ring;

    int errors = 0;
    int checks = 0;

    alarm_ctrl #(.W(2), .RING_TICKS(RING), .SNOOZE_TICKS(SNZ), .MAX_SNOOZE(MAXS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick          (tick),
        .hours         (hours),
        .minutes       (minutes),
        .seconds       (seconds),
        .set_btn       (set_btn),
        .inc_btn       (inc_btn),
        .arm_btn       (arm_btn),
        .snooze_btn    (snooze_btn),
        .stop_btn      (stop_btn),
        .alarm_hours   (alarm_hours),
        .alarm_minutes (alarm_minutes),
        .state         (state),
        .armed         (armed),
        .ring          (ring)
    );

    always #5 clk = ~clk;

    // Behavioural model: remaining-tick countdowns and a snoozes-left budget.
    alarm_state_e m_st;
    logic [1:0]   m_ah, m_am;
    logic         m_prev_match;
    int           m_ring_left, m_snz_left, m_snz_budget;

    task automatic model_reset();
        m_st = StIdle; m_ah = 2'd0; m_am = 2'd0; m_prev_match = 1'b0;
        m_ring_left = 0; m_snz_left = 0; m_snz_budget = MAXS;
    endtask

    task automatic model_step(input logic t, input logic [1:0] h, input logic [1:0] m,
                              input logic [1:0] s, input logic sb, input logic ib,
                              input logic ab, input logic zb, input logic pb);
        string b;
        logic  hit, fire;
        alarm_state_e nxt;
        b = pb ? "stop" : ab ? "arm" : zb ? "snooze" : sb ? "set" : ib ? "inc" : "none";
        hit  = (h == m_ah) && (m == m_am) && (s == 2'd0);
        fire = hit && !m_prev_match;
        m_prev_match = hit;
        nxt = m_st;
        case (m_st)
            StIdle:  if (b == "arm") nxt = StArmed; else if (b == "set") nxt = StSetH;
            StSetH: begin
                if (b == "inc") m_ah = m_ah + 2'd1;
                else if (b == "set") nxt = StSetM;
                else if (b == "arm") nxt = StIdle;
            end
            StSetM: begin
                if (b == "inc") m_am = m_am + 2'd1;
                else if (b == "set") nxt = StIdle;
                else if (b == "arm") nxt = StArmed;
            end
            StArmed: begin
                if (b == "arm") nxt = StIdle;
                else if (b == "set") nxt = StSetH;
                else if (fire) begin nxt = StRinging; m_ring_left = RING; end
            end
            StRinging: begin
                if (b == "stop") nxt = StArmed;
                else if (b == "arm") nxt = StIdle;
                else if (b == "snooze" && m_snz_budget > 0) begin
                    nxt = StSnooze; m_snz_left = SNZ; m_snz_budget--;
                end else if (t) begin
                    m_ring_left--;
                    if (m_ring_left == 0) nxt = StArmed;
                end
            end
            StSnooze: begin
                if (b == "stop") nxt = StArmed;
                else if (b == "arm") nxt = StIdle;
                else if (t) begin
                    m_snz_left--;
                    if (m_snz_left == 0) begin nxt = StRinging; m_ring_left = RING; end
                end
            end
            default: nxt = StIdle;
        endcase
        if (nxt == StIdle || nxt == StArmed) m_snz_budget = MAXS;
        m_st = nxt;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic t, input logic [1:0] h,
                       input logic [1:0] m, input logic [1:0] s, input logic sb,
                       input logic ib, input logic ab, input logic zb, input logic pb);
        logic [8:0] exp_v;
        tick = t; hours = h; minutes = m; seconds = s;
        set_btn = sb; inc_btn = ib; arm_btn = ab; snooze_btn = zb; stop_btn = pb;
        model_step(t, h, m, s, sb, ib, ab, zb, pb);
        @(posedge clk);
        @(negedge clk);
        exp_v = {m_st, m_st == StRinging,
                 m_st == StArmed || m_st == StRinging || m_st == StSnooze, m_ah, m_am};
        check_val(tag, {23'd0, state, ring, armed, alarm_hours, alarm_minutes},
                  {23'd0, exp_v});
    endtask

    typedef struct {
        logic         set, inc, arm, stop;
        alarm_state_e st;
        logic [1:0]   ah, am;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic i, input logic a, input logic p,
                                input alarm_state_e st, input logic [1:0] ah,
                                input logic [1:0] am);
        vec_t v;
        v.set = s; v.inc = i; v.arm = a; v.stop = p; v.st = st; v.ah = ah; v.am = am;
        return v;
    endfunction

    vec_t vecs[15];

    initial begin
        vecs[0]  = mk(1, 0, 0, 0, StSetH,  2'd0, 2'd0);
        vecs[1]  = mk(0, 1, 0, 0, StSetH,  2'd1, 2'd0);
        vecs[2]  = mk(0, 1, 0, 0, StSetH,  2'd2, 2'd0);
        vecs[3]  = mk(0, 1, 0, 0, StSetH,  2'd3, 2'd0);
        vecs[4]  = mk(0, 1, 0, 0, StSetH,  2'd0, 2'd0);
        vecs[5]  = mk(0, 1, 0, 0, StSetH,  2'd1, 2'd0);
        vecs[6]  = mk(1, 0, 0, 0, StSetM,  2'd1, 2'd0);
        vecs[7]  = mk(0, 1, 0, 0, StSetM,  2'd1, 2'd1);
        vecs[8]  = mk(0, 1, 0, 0, StSetM,  2'd1, 2'd2);
        vecs[9]  = mk(1, 0, 0, 0, StIdle,  2'd1, 2'd2);
        vecs[10] = mk(0, 1, 0, 0, StIdle,  2'd1, 2'd2);
        vecs[11] = mk(1, 1, 0, 0, StSetH,  2'd1, 2'd2);
        vecs[12] = mk(1, 1, 0, 0, StSetM,  2'd1, 2'd2);
        vecs[13] = mk(1, 0, 1, 0, StArmed, 2'd1, 2'd2);
        vecs[14] = mk(0, 0, 1, 1, StArmed, 2'd1, 2'd2);

        rst_n = 1'b0;
        tick = 0; hours = 2'd3; minutes = 2'd3; seconds = 2'd1;
        set_btn = 0; inc_btn = 0; arm_btn = 0; snooze_btn = 0; stop_btn = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_val("reset_outputs", {armed, ring, state, alarm_hours, alarm_minutes}, 0);

        for (int i = 0; i < 15; i++) begin
            cyc("vec_model", 0, 2'd3, 2'd3, 2'd1, vecs[i].set, vecs[i].inc, vecs[i].arm, 0,
                vecs[i].stop);
            check_val($sformatf("vec%0d", i), {state, alarm_hours, alarm_minutes},
                      {vecs[i].st, vecs[i].ah, vecs[i].am});
        end

        // Match held for 10 cycles rings once; stop during the same match does not re-ring.
        cyc("pre_match", 0, 2'd1, 2'd2, 2'd3, 0, 0, 0, 0, 0);
        check_val("pre_match_ring", ring, 0);
        for (int i = 0; i < 10; i++) begin
            cyc("held_match", 0, 2'd1, 2'd2, 2'd0, 0, 0, 0, 0, 0);
            check_val("ring_after_match", ring, 1);
        end
        cyc("stop", 0, 2'd1, 2'd2, 2'd0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc("no_retrigger", 0, 2'd1, 2'd2, 2'd0, 0, 0, 0, 0, 0);
        check_val("no_retrigger_state", state, StArmed);

        // Timeout after RING ticks.
        cyc("rearm", 0, 2'd0, 2'd0, 2'd1, 0, 0, 0, 0, 0);
        cyc("trig2", 0, 2'd1, 2'd2, 2'd0, 0, 0, 0, 0, 0);
        for (int i = 0; i < RING; i++) begin
            cyc("timeout_tick", 1, 2'd1, 2'd2, 2'd0, 0, 0, 0, 0, 0);
            check_val("timeout_ring", ring, (i < RING - 1) ? 1 : 0);
        end
        check_val("timeout_state", state, StArmed);

        // Bounded snooze: MAXS snoozes honoured, the next ignored.
        cyc("rearm3", 0, 2'd0, 2'd0, 2'd1, 0, 0, 0, 0, 0);
        cyc("trig3", 0, 2'd1, 2'd2, 2'd0, 0, 0, 0, 0, 0);
        for (int k = 0; k < MAXS; k++) begin
            cyc("snooze", 0, 2'd1, 2'd2, 2'd0, 0, 0, 0, 1, 0);
            check_val("snooze_state", state, StSnooze);
            for (int j = 0; j < SNZ; j++) begin
                cyc("snz_tick", 1, 2'd1, 2'd2, 2'd0, 0, 0, 0, 0, 0);
                check_val("snz_ring", ring, (j == SNZ - 1) ? 1 : 0);
            end
        end
        cyc("snooze_exhausted", 0, 2'd1, 2'd2, 2'd0, 0, 0, 0, 1, 0);
        check_val("snooze_exhausted_ring", ring, 1);

        // stop + snooze + tick together: stop wins and the snooze budget refills.
        cyc("stop_snz_tick", 1, 2'd1, 2'd2, 2'd0, 0, 0, 0, 1, 1);
        check_val("stop_snz_tick_state", state, StArmed);
        check_val("snooze_used_clear", 32'(dut.snooze_used_q), 0);

        // Asynchronous reset mid-snooze.
        cyc("rearm4", 0, 2'd0, 2'd0, 2'd1, 0, 0, 0, 0, 0);
        cyc("trig4", 0, 2'd1, 2'd2, 2'd0, 0, 0, 0, 0, 0);
        cyc("snooze4", 0, 2'd1, 2'd2, 2'd0, 0, 0, 0, 1, 0);
        cyc("snz4_tick", 1, 2'd1, 2'd2, 2'd0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 check_val("async_reset", {armed, ring, state, alarm_hours, alarm_minutes}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        begin
            logic [1:0] h, m, s;
            h = 2'd0; m = 2'd0; s = 2'd1;
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    h = 2'($urandom_range(0, 3));
                    m = 2'($urandom_range(0, 3));
                    s = ($urandom_range(0, 2) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
                end
                cyc("random", $urandom_range(0, 1) == 1, h, m, s,
                    $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 19) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
